serial_adder: RTL and testbench

Bit-serial, LSB-first adder. It accepts two WIDTH-bit operands and a carry-in through a valid/ready handshake. It then produces the WIDTH-bit sum and carry-out after WIDTH shift cycles. The datapath is one full_adder cell, built from two half_adder instances plus an OR, with a registered carry. It sits directly downstream of half_adder and is the first sequential consumer of that cell in the building-blocks set.

---
 rtl/serial_adder_pkg.sv | 12 +
 rtl/full_adder.sv | 31 +++
 rtl/half_adder.sv | 12 +
 rtl/serial_adder.sv | 91 +++++++++
 tb/tb_serial_adder.sv | 179 +++++++++++++++++
 5 files changed

// File: rtl/serial_adder_pkg.sv
// Shared types and constants for the bit-serial adder.
package serial_adder_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam int DEFAULT_WIDTH = 8;

endpackage

// File: rtl/full_adder.sv
// Single-bit full adder built from two half adders and an OR.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic co
);

  logic s1;
  logic carry1;
  logic carry2;

  half_adder u_ha0 (
    .a  (a),
    .b  (b),
    .s  (s1),
    .co (carry1)
  );

  half_adder u_ha1 (
    .a  (s1),
    .b  (cin),
    .s  (s),
    .co (carry2)
  );

  // Both half-adder carries can never be high together, so OR is exact.
  assign co = carry1 | carry2;

endmodule

// File: rtl/half_adder.sv
// Single-bit half adder: sum and carry of two bits.
module half_adder (
  input  logic a,
  input  logic b,
  output logic s,
  output logic co
);

  assign s  = a ^ b;
  assign co = a & b;

endmodule

// File: rtl/serial_adder.sv
// Bit-serial LSB-first adder: one full_adder cell, registered carry,
// WIDTH shift cycles per operation, valid/ready on both sides.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Sum,
  output logic             Carry,
  output logic             busy
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] sum_sh;
  logic             carry;
  logic [CNT_W-1:0] cnt;
  logic             fa_s;
  logic             fa_co;
  logic             accept;

  full_adder u_fa (
    .a   (a_sh[0]),
    .b   (b_sh[0]),
    .cin (carry),
    .s   (fa_s),
    .co  (fa_co)
  );

  assign accept = (state == IDLE) && in_valid;

  // NOTE: every output of always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (in_valid)          state_nxt = SHIFT;
      SHIFT:   if (cnt == CNT_LAST)   state_nxt = DONE;
      DONE:    if (out_ready)         state_nxt = IDLE;
      default:                        state_nxt = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      a_sh   <= '0;
      b_sh   <= '0;
      sum_sh <= '0;
      carry  <= 1'b0;
      cnt    <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        a_sh   <= A;
        b_sh   <= B;
        sum_sh <= '0;
        carry  <= Cin;
        cnt    <= '0;
      end else if (state == SHIFT) begin
        sum_sh <= {fa_s, sum_sh[WIDTH-1:1]};
        a_sh   <= a_sh >> 1;
        b_sh   <= b_sh >> 1;
        carry  <= fa_co;
        cnt    <= cnt + 1'b1;
      end
    end
  end

  // Handshake outputs depend on state only; no input-to-output combinational path.
  assign in_ready  = (state == IDLE);
  assign busy      = (state == SHIFT);
  assign out_valid = (state == DONE);
  assign Sum       = sum_sh;
  assign Carry     = carry;

endmodule

// File: tb/tb_serial_adder.sv
// Directed self-checking bench for serial_adder at WIDTH=8.
module tb_serial_adder;

  localparam int WIDTH = 8;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             Cin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] Sum;
  logic             Carry;
  logic             busy;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  serial_adder #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .A         (A),
    .B         (B),
    .Cin       (Cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .Sum       (Sum),
    .Carry     (Carry),
    .busy      (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One full transaction; optionally pokes in_valid mid-SHIFT and stalls in DONE.
  task automatic do_add(input string tag, input logic [7:0] a, input logic [7:0] b,
                        input logic cin, input logic [7:0] es, input logic ec,
                        input int hold, input bit glitch);
    int  n;
    bit  ok;
    logic [7:0] s0;
    logic       c0;
    A = a; B = b; Cin = cin; in_valid = 1'b1; out_ready = 1'b0;
    n = 0;
    while (!in_ready && n < 20) begin tick(); n++; end
    check({tag, " ready"}, {31'd0, in_ready}, 32'd1);
    tick();
    in_valid = 1'b0;
    n  = 0;
    ok = 1'b1;
    while (!out_valid && n < 40) begin
      if (!busy || in_ready) ok = 1'b0;
      if (glitch && n == 2) begin
        in_valid = 1'b1; A = 8'h33; B = 8'h33; Cin = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      tick();
      n++;
    end
    in_valid = 1'b0;
    check({tag, " latency"}, n, 32'd8);
    check({tag, " busy"}, {31'd0, ok}, 32'd1);
    check({tag, " sum"}, {24'd0, Sum}, {24'd0, es});
    check({tag, " carry"}, {31'd0, Carry}, {31'd0, ec});
    if (hold > 0) begin
      s0 = Sum; c0 = Carry; ok = 1'b1;
      in_valid = 1'b1; A = 8'h77; B = 8'h11;
      for (int i = 0; i < hold; i++) begin
        tick();
        if (Sum !== s0 || Carry !== c0 || in_ready || !out_valid) ok = 1'b0;
      end
      check({tag, " hold stable"}, {31'd0, ok}, 32'd1);
      check({tag, " hold sum"}, {24'd0, Sum}, {24'd0, es});
    end
    out_ready = 1'b1;
    tick();
    in_valid  = 1'b0;
    out_ready = 1'b0;
    check({tag, " valid drop"}, {31'd0, out_valid}, 32'd0);
    check({tag, " idle"}, {31'd0, in_ready}, 32'd1);
  endtask

  initial begin
    int n;
    int t1;
    int t2;
    bit ok;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    A = '0; B = '0; Cin = 1'b0;
    repeat (3) tick();
    check("rst in_ready", {31'd0, in_ready}, 32'd1);
    check("rst out_valid", {31'd0, out_valid}, 32'd0);
    check("rst busy", {31'd0, busy}, 32'd0);
    check("rst sum", {24'd0, Sum}, 32'h00);
    check("rst carry", {31'd0, Carry}, 32'd0);
    rst_n = 1'b1;
    tick();

    do_add("basic", 8'h0F, 8'h01, 1'b0, 8'h10, 1'b0, 0, 1'b0);
    do_add("chain", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 0, 1'b1);
    do_add("cin",   8'hA5, 8'h5A, 1'b1, 8'h00, 1'b1, 5, 1'b0);

    // Back-to-back with out_ready tied high.
    out_ready = 1'b1;
    A = 8'h12; B = 8'h34; Cin = 1'b0; in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 20) begin tick(); n++; end
    tick();
    t1 = cyc;
    A = 8'h80; B = 8'h80;
    n = 0; ok = 1'b0;
    while (!in_ready && n < 40) begin
      if (out_valid) begin
        ok = 1'b1;
        check("b2b1 sum", {24'd0, Sum}, 32'h46);
        check("b2b1 carry", {31'd0, Carry}, 32'd0);
      end
      tick();
      n++;
    end
    check("b2b1 seen", {31'd0, ok}, 32'd1);
    tick();
    t2 = cyc;
    in_valid = 1'b0;
    check("b2b interval", t2 - t1, 32'd10);
    n = 0;
    while (!out_valid && n < 40) begin tick(); n++; end
    check("b2b2 latency", n, 32'd8);
    check("b2b2 sum", {24'd0, Sum}, 32'h00);
    check("b2b2 carry", {31'd0, Carry}, 32'd1);
    tick();
    out_ready = 1'b0;
    check("b2b2 idle", {31'd0, in_ready}, 32'd1);

    // Reset three cycles into SHIFT.
    A = 8'h55; B = 8'h11; Cin = 1'b0; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (3) tick();
    check("mid busy pre", {31'd0, busy}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("mid rst in_ready", {31'd0, in_ready}, 32'd1);
    check("mid rst busy", {31'd0, busy}, 32'd0);
    check("mid rst valid", {31'd0, out_valid}, 32'd0);
    check("mid rst sum", {24'd0, Sum}, 32'h00);
    tick();
    rst_n = 1'b1;
    ok = 1'b1;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (out_valid) ok = 1'b0;
    end
    check("mid no valid", {31'd0, ok}, 32'd1);
    do_add("post", 8'h01, 8'h01, 1'b0, 8'h02, 1'b0, 0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
